// File: rtl/enc8to3_serial.sv
// enc8to3_serial: sequential 8:3 encoder.
// An accepted 8-bit request mask is served one set bit per output beat as a
// 3-bit binary index. out_last marks the final set bit of the mask.
// Accepting an all-zero mask produces a one-cycle zero_err pulse and no beats.
// Optional macro ENC_MSB_FIRST_EN: serve the highest set bit first instead of
// the lowest. Only the order changes; handshake and latency are the same.
module enc8to3_serial (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [2:0] out,
   output logic       out_last,
   output logic       zero_err
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t     state_reg, state_next;
   logic [7:0] pend_reg, pend_next;
   logic       zero_err_reg, zero_err_next;

   logic [7:0] serve_mask;   // one-hot: the bit of pend being served now
   logic [2:0] serve_idx;    // binary index of serve_mask
   logic [7:0] pend_rest;    // pend with the served bit removed
   logic       one_left;     // exactly one bit remains in pend

   // Priority pick: isolate the bit of pend that is served this cycle
   always_comb begin
      logic seen;
      seen       = 1'b0;
      serve_mask = 8'h00;
`ifdef ENC_MSB_FIRST_EN
      for (int i = 7; i >= 0; i--) begin
         if (pend_reg[i] && !seen) begin
            serve_mask[i] = 1'b1;
            seen          = 1'b1;
         end
      end
`else
      for (int i = 0; i < 8; i++) begin
         if (pend_reg[i] && !seen) begin
            serve_mask[i] = 1'b1;
            seen          = 1'b1;
         end
      end
`endif
   end

   // Encode the one-hot served bit into its binary index
   always_comb begin
      serve_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (serve_mask[i]) begin
            serve_idx = serve_idx | 3'(i);
         end
      end
   end

   // Remaining mask after the current beat, and the last-beat flag.
   // The last-beat test is order independent, so it uses pend & (pend-1).
   always_comb begin
      pend_rest = pend_reg & ~serve_mask;
      one_left  = ((pend_reg & (pend_reg - 8'd1)) == 8'h00);
   end

   // State register: FSM, pending mask and the zero-vector pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         pend_reg     <= 8'h00;
         zero_err_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         pend_reg     <= pend_next;
         zero_err_reg <= zero_err_next;
      end
   end

   // Next-state logic: accept a mask in IDLE, retire one bit per beat in BUSY
   always_comb begin
      state_next    = state_reg;
      pend_next     = pend_reg;
      zero_err_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               if (in != 8'h00) begin
                  pend_next  = in;
                  state_next = BUSY;
               end else begin
                  zero_err_next = 1'b1;
               end
            end
         end
         BUSY: begin
            if (out_ready) begin
               pend_next = pend_rest;
               if (one_left) begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
            pend_next  = 8'h00;
         end
      endcase
   end

   // Outputs depend only on registered state; nothing combinational from inputs
   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == BUSY);
      out       = (state_reg == BUSY) ? serve_idx : 3'd0;
      out_last  = (state_reg == BUSY) && one_left;
      zero_err  = zero_err_reg;
   end

endmodule

// File: tb/tb_enc8to3_serial.sv
// tb_enc8to3_serial: table-driven, hand-written and randomized checks of
// enc8to3_serial against a behavioural model of the served index sequence.
// Honours ENC_MSB_FIRST_EN the same way as the design.
module tb_enc8to3_serial;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out;
   logic       out_last;
   logic       zero_err;

   int compared   = 0;
   int mismatched = 0;

   enc8to3_serial dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_last  (out_last),
      .zero_err  (zero_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] mask;       // request vector
      int         rmode;      // 0: ready always, 1: 1,0,0 repeating, 2: random
      bit         hold;       // keep in_valid high with changing in while busy
      int         exp_first;  // first code expected
      int         exp_beats;  // number of beats expected
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: ordered list of set-bit indices of a mask
   function automatic void model(input logic [7:0] mask, output int codes[$]);
      codes = {};
`ifdef ENC_MSB_FIRST_EN
      for (int i = 7; i >= 0; i--) if (mask[i]) codes.push_back(i);
`else
      for (int i = 0; i < 8; i++) if (mask[i]) codes.push_back(i);
`endif
   endfunction

   // Present a mask when in_ready is high; check the cycle after acceptance
   task automatic send(input logic [7:0] mask);
      int waited;
      waited = 0;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      in       = mask;
      @(negedge clk);
      in_valid = 1'b0;
      in       = 8'($urandom);
      if (mask == 8'h00) begin
         chk("zero_err_pulse", int'(zero_err), 1);
         chk("zero_out_valid", int'(out_valid), 0);
         chk("zero_in_ready", int'(in_ready), 1);
         @(negedge clk);
         chk("zero_err_clear", int'(zero_err), 0);
         chk("zero_out_valid2", int'(out_valid), 0);
      end else begin
         chk("accept_out_valid", int'(out_valid), 1);
         chk("accept_in_ready", int'(in_ready), 0);
      end
   endtask

   // Drain up to max_beats beats, checking each presented beat against the model
   task automatic drain(input logic [7:0] mask, input int rmode, input bit hold,
                        input int max_beats, output int nbeats, output int first);
      int  q[$];
      int  cyc;
      bit  r;
      model(mask, q);
      nbeats = 0;
      first  = -1;
      cyc    = 0;
      while (q.size() > 0 && nbeats < max_beats && cyc < 200) begin
         case (rmode)
            0:       r = 1'b1;
            1:       r = (cyc % 3 == 0);
            default: r = 1'($urandom_range(0, 1));
         endcase
         out_ready = r;
         if (hold) begin
            in_valid = 1'b1;
            in       = 8'($urandom);
         end
         chk("beat_out_valid", int'(out_valid), 1);
         chk("beat_in_ready", int'(in_ready), 0);
         chk("beat_code", int'(out), q[0]);
         chk("beat_last", int'(out_last), (q.size() == 1) ? 1 : 0);
         if (first < 0) first = int'(out);
         if (r) begin
            void'(q.pop_front());
            nbeats++;
         end
         cyc++;
         @(negedge clk);
      end
      if (cyc >= 200) chk("drain_timeout", 0, 1);
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      vec_t vt[6];
      int   nb, fc;

      vt[0] = '{8'h04, 0, 1'b0, 2, 1};
`ifdef ENC_MSB_FIRST_EN
      vt[1] = '{8'hA5, 0, 1'b0, 7, 4};
      vt[2] = '{8'hFF, 1, 1'b0, 7, 8};
      vt[5] = '{8'h3C, 2, 1'b1, 5, 4};
`else
      vt[1] = '{8'hA5, 0, 1'b0, 0, 4};
      vt[2] = '{8'hFF, 1, 1'b0, 0, 8};
      vt[5] = '{8'h3C, 2, 1'b1, 2, 4};
`endif
      vt[3] = '{8'h00, 0, 1'b0, -1, 0};
      vt[4] = '{8'h80, 0, 1'b0, 7, 1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in        = 8'h00;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out", int'(out), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_zero_err", int'(zero_err), 0);
      rst = 1'b0;
      @(negedge clk);

      // Table-driven vectors
      foreach (vt[k]) begin
         send(vt[k].mask);
         if (vt[k].mask != 8'h00) begin
            drain(vt[k].mask, vt[k].rmode, vt[k].hold, 8, nb, fc);
            chk($sformatf("tbl%0d_first", k), fc, vt[k].exp_first);
            chk($sformatf("tbl%0d_beats", k), nb, vt[k].exp_beats);
            chk($sformatf("tbl%0d_ready_back", k), int'(in_ready), 1);
            chk($sformatf("tbl%0d_valid_drop", k), int'(out_valid), 0);
            chk($sformatf("tbl%0d_last_drop", k), int'(out_last), 0);
         end
      end

      // Reset in the middle of a vector discards what is pending
      send(8'h0F);
      drain(8'h0F, 0, 1'b0, 2, nb, fc);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_out_last", int'(out_last), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      chk("midrst_out", int'(out), 0);
      rst = 1'b0;
      @(negedge clk);
      send(8'h10);
      drain(8'h10, 0, 1'b0, 8, nb, fc);
      chk("postrst_first", fc, 4);
      chk("postrst_beats", nb, 1);
      chk("postrst_idle", int'(out_valid), 0);

      // Reset dominates a handshake in the same cycle
      in_valid = 1'b1;
      in       = 8'h21;
      rst      = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b0;
      chk("rst_vs_accept_valid", int'(out_valid), 0);
      chk("rst_vs_accept_ready", int'(in_ready), 1);
      @(negedge clk);

      // Randomized masks and ready patterns against the model
      for (int t = 0; t < 40; t++) begin
         logic [7:0] m;
         int         exp_q[$];
         m = 8'($urandom);
         if (t % 10 == 0) m = 8'h00;
         model(m, exp_q);
         send(m);
         if (m != 8'h00) begin
            drain(m, 2, 1'($urandom_range(0, 1)), 8, nb, fc);
            chk("rnd_beats", nb, exp_q.size());
            chk("rnd_ready_back", int'(in_ready), 1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
